// File: rtl/opfifo_pkg.sv
// opfifo_pkg: shared channel indices, default sizing and a clog2 helper for the operand FIFO bank
package opfifo_pkg;
  localparam int CH_R2 = 0;
  localparam int CH_N = 1;
  localparam int CH_M = 2;
  localparam int CH_PHI = 3;
  localparam int CH_EI = 4;
  localparam int DEF_NUM_CH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_AFULL_THRESH = 240;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/operand_fifo_bank_if.sv
// operand_fifo_bank_if: packed per-channel write/read/flush requests and status of the operand FIFO bank
interface operand_fifo_bank_if
  import opfifo_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int LW = clog2(DEPTH) + 1;
  logic [NUM_CH*DATA_WIDTH-1:0] din;
  logic [NUM_CH*DATA_WIDTH-1:0] dout;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic [NUM_CH-1:0] flush;
  logic err_clr;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] almost_full;
  logic [NUM_CH*LW-1:0] level;
  logic [NUM_CH-1:0] ovf_err;
  logic [NUM_CH-1:0] udf_err;
  modport master (
    output din, wr_en, rd_en, flush, err_clr,
    input dout, empty, full, almost_full, level, ovf_err, udf_err
  );
  modport slave (
    input din, wr_en, rd_en, flush, err_clr,
    output dout, empty, full, almost_full, level, ovf_err, udf_err
  );
endinterface

// File: rtl/opfifo_ch.sv
// opfifo_ch: one operand FIFO channel with level, status and sticky errors; OPFIFO_FWFT_EN selects first-word-fall-through
module opfifo_ch
  import opfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH,
  localparam int AW = clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic wr_en,
  input  logic rd_en,
  input  logic flush,
  input  logic err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic almost_full,
  output logic [LW-1:0] level,
  output logic ovf_err,
  output logic udf_err
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic wr_acc, rd_acc;
  assign level = level_q;
  assign empty = level_q == '0;
  assign full = level_q == LW'(DEPTH);
  assign almost_full = level_q >= LW'(AFULL_THRESH);
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
  // acceptance, pointer/level update and sticky errors; flush silences requests and their errors
  always_comb begin
    wr_acc = wr_en & ~full & ~flush;
    rd_acc = rd_en & ~empty & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_acc);
    level_d = flush ? '0 : level_q + LW'(wr_acc) - LW'(rd_acc);
    ovf_d = (wr_en & full & ~flush) | (ovf_q & ~err_clr);
    udf_d = (rd_en & empty & ~flush) | (udf_q & ~err_clr);
  end
  // control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  // storage is not reset; only accepted writes land
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= din;
  end
`ifdef OPFIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  assign dout = dout_q;
  // output word is captured only when a read is accepted and held otherwise
  always_comb begin
    dout_d = rd_acc ? mem[rd_ptr_q] : dout_q;
  end
  // output register
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else dout_q <= dout_d;
  end
`endif
endmodule

// File: rtl/operand_fifo_bank.sv
// operand_fifo_bank: NUM_CH independent operand FIFOs between the burst reader and the Montgomery datapath; OPFIFO_FWFT_EN selects FWFT reads
module operand_fifo_bank
  import opfifo_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input logic clk,
  input logic rst,
  operand_fifo_bank_if.slave bus
);
  localparam int LW = clog2(DEPTH) + 1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    opfifo_ch #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH(DEPTH),
      .AFULL_THRESH(AFULL_THRESH)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .din(bus.din[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_en(bus.wr_en[c]),
      .rd_en(bus.rd_en[c]),
      .flush(bus.flush[c]),
      .err_clr(bus.err_clr),
      .dout(bus.dout[c*DATA_WIDTH +: DATA_WIDTH]),
      .empty(bus.empty[c]),
      .full(bus.full[c]),
      .almost_full(bus.almost_full[c]),
      .level(bus.level[c*LW +: LW]),
      .ovf_err(bus.ovf_err[c]),
      .udf_err(bus.udf_err[c])
    );
  end
endmodule

// File: tb/tb_operand_fifo_bank.sv
// tb_operand_fifo_bank: directed and random stimulus checked against a queue-based reference model
module tb_operand_fifo_bank;
  localparam int NC = 5;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC*DW-1:0] din_p = '0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q [NC][$];
  logic m_ovf [NC];
  logic m_udf [NC];
  logic [DW-1:0] m_dout [NC];
  operand_fifo_bank_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
  operand_fifo_bank #(.NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_din(input int c, input logic [DW-1:0] v);
    din_p[c*DW +: DW] = v;
  endtask

  task automatic model(input logic [NC-1:0] wr, rd, fl, input logic ec, r);
    for (int c = 0; c < NC; c++) begin
      int n;
      n = q[c].size();
      if (r) begin
        q[c].delete();
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
        m_dout[c] = '0;
      end else begin
        if (fl[c]) q[c].delete();
        else begin
          if (rd[c] && n > 0) begin
            m_dout[c] = q[c][0];
            void'(q[c].pop_front());
          end
          if (wr[c] && n < DEPTH) q[c].push_back(din_p[c*DW +: DW]);
        end
        m_ovf[c] = (!fl[c] && wr[c] && n == DEPTH) || (m_ovf[c] && !ec);
        m_udf[c] = (!fl[c] && rd[c] && n == 0) || (m_udf[c] && !ec);
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      int n;
      logic [DW-1:0] ed;
      n = q[c].size();
`ifdef OPFIFO_FWFT_EN
      ed = n > 0 ? q[c][0] : '0;
`else
      ed = m_dout[c];
`endif
      chk($sformatf("level[%0d]", c), bus.level[c*LW +: LW], n);
      chk($sformatf("empty[%0d]", c), bus.empty[c], n == 0);
      chk($sformatf("full[%0d]", c), bus.full[c], n == DEPTH);
      chk($sformatf("almost_full[%0d]", c), bus.almost_full[c], n >= AF);
      chk($sformatf("ovf_err[%0d]", c), bus.ovf_err[c], m_ovf[c]);
      chk($sformatf("udf_err[%0d]", c), bus.udf_err[c], m_udf[c]);
      chk($sformatf("dout[%0d]", c), bus.dout[c*DW +: DW], ed);
    end
  endtask

  task automatic step(input logic [NC-1:0] wr, rd, fl, input logic ec = 1'b0, input logic r = 1'b0);
    bus.din = din_p;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.flush = fl;
    bus.err_clr = ec;
    rst = r;
    @(posedge clk);
    model(wr, rd, fl, ec, r);
    #1;
    compare_all();
  endtask

  initial begin
    bus.din = '0;
    bus.wr_en = '0;
    bus.rd_en = '0;
    bus.flush = '0;
    bus.err_clr = 1'b0;
    for (int c = 0; c < NC; c++) set_din(c, $urandom);
    step(5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b1);
    chk("reset_empty", bus.empty, 5'b11111);
    // fill ch1 in order
    for (int i = 0; i < 16; i++) begin
      set_din(1, 32'h1000 + i);
      step(5'b00010, 5'b00000, 5'b00000);
      if (i == 10) chk("af1_after11", bus.almost_full[1], 1'b0);
      if (i == 11) chk("af1_after12", bus.almost_full[1], 1'b1);
      if (i == 14) chk("full1_after15", bus.full[1], 1'b0);
    end
    chk("full1_after16", bus.full[1], 1'b1);
    chk("level1_16", bus.level[1*LW +: LW], 16);
    for (int i = 0; i < 16; i++) begin
`ifndef OPFIFO_FWFT_EN
      step(5'b00000, 5'b00010, 5'b00000);
      chk("dout1_order", bus.dout[1*DW +: DW], 32'h1000 + i);
`else
      chk("dout1_head", bus.dout[1*DW +: DW], 32'h1000 + i);
      step(5'b00000, 5'b00010, 5'b00000);
`endif
    end
    chk("empty1_drained", bus.empty[1], 1'b1);
    // ch0/ch4 interleave, reads on ch4 only
    for (int i = 0; i < 10; i++) begin
      set_din(0, 32'hA0 + i);
      set_din(4, 32'hE0 + i);
      step(5'b10001, i > 0 ? 5'b10000 : 5'b00000, 5'b00000);
    end
    chk("level0_indep", bus.level[0*LW +: LW], 10);
    chk("level4_indep", bus.level[4*LW +: LW], 1);
    // full/empty collisions
    for (int i = 0; i < 16; i++) begin
      set_din(2, $urandom);
      step(5'b00100, 5'b00000, 5'b00000);
    end
    set_din(2, 32'hDEAD);
    step(5'b00100, 5'b00100, 5'b00000);
    chk("ovf2_set", bus.ovf_err[2], 1'b1);
    chk("level2_15", bus.level[2*LW +: LW], 15);
    set_din(3, 32'h55);
    step(5'b01000, 5'b01000, 5'b00000);
    chk("udf3_set", bus.udf_err[3], 1'b1);
    chk("level3_1", bus.level[3*LW +: LW], 1);
    step(5'b00000, 5'b00000, 5'b00000, 1'b1);
    chk("errs_cleared", {bus.ovf_err, bus.udf_err}, 10'b0);
    // wrap-around on ch0 at constant level 3
    step(5'b00000, 5'b00000, 5'b00001);
    for (int i = 0; i < 40; i++) begin
      set_din(0, i);
      step(5'b00001, i >= 3 ? 5'b00001 : 5'b00000, 5'b00000);
    end
    for (int i = 0; i < 3; i++) step(5'b00000, 5'b00001, 5'b00000);
    chk("empty0_wrap", bus.empty[0], 1'b1);
    // flush overrides a write on ch1
    for (int i = 0; i < 7; i++) begin
      set_din(1, 32'h2000 + i);
      step(5'b00010, 5'b00000, 5'b00000);
    end
    step(5'b00010, 5'b00000, 5'b00010);
    chk("level1_flush", bus.level[1*LW +: LW], 0);
    chk("ovf1_flush", bus.ovf_err[1], 1'b0);
    // mid-operation reset
    for (int i = 0; i < 5; i++) begin
      set_din(0, $urandom);
      step(5'b00001, 5'b00000, 5'b00000);
    end
    step(5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b1);
    chk("level_rst", bus.level, '0);
    chk("dout_rst", bus.dout[63:0], 64'h0);
    // randomized traffic, filling bias then draining bias
    for (int i = 0; i < 600; i++) begin
      logic [NC-1:0] wr, rd, fl;
      for (int c = 0; c < NC; c++) set_din(c, $urandom);
      wr = i < 300 ? NC'($urandom | $urandom) : NC'($urandom & $urandom);
      rd = i < 300 ? NC'($urandom & $urandom) : NC'($urandom | $urandom);
      fl = $urandom_range(0, 31) == 0 ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
      step(wr, rd, fl, $urandom_range(0, 15) == 0, $urandom_range(0, 249) == 0);
    end
`ifdef OPFIFO_FWFT_EN
    step(5'b00000, 5'b00000, 5'b00000, 1'b0, 1'b1);
    set_din(2, 32'h77);
    step(5'b00100, 5'b00000, 5'b00000);
    chk("fwft_head", bus.dout[2*DW +: DW], 32'h77);
    step(5'b00000, 5'b00100, 5'b00000);
    chk("fwft_pop_dout", bus.dout[2*DW +: DW], 32'h0);
    chk("fwft_pop_empty", bus.empty[2], 1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
